// File: rtl/fp_instr_encoder.sv
// RV32F field-to-word encoder with legality check, output FIFO and saturating stats.
// Illegal requests are queued as a zero word flagged out_illegal, so request order is kept.
module fp_instr_encoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       fp_op,
  input  logic [6:0]       func,
  input  logic [1:0]       fmt,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [4:0]       rs3,
  input  logic [4:0]       rd,
  input  logic [11:0]      offset,
  input  logic [2:0]       rm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_illegal,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] illegal_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [6:0] OP_FLW    = 7'h07;
  localparam logic [6:0] OP_FSW    = 7'h27;
  localparam logic [6:0] OP_FMADD  = 7'h43;
  localparam logic [6:0] OP_FMSUB  = 7'h47;
  localparam logic [6:0] OP_FNMSUB = 7'h4B;
  localparam logic [6:0] OP_FNMADD = 7'h4F;
  localparam logic [6:0] OP_FP     = 7'h53;

  localparam logic [6:0] F_FADD    = 7'h00;
  localparam logic [6:0] F_FSUB    = 7'h04;
  localparam logic [6:0] F_FMUL    = 7'h08;
  localparam logic [6:0] F_FDIV    = 7'h0C;
  localparam logic [6:0] F_FSQRT   = 7'h2C;
  localparam logic [6:0] F_FSGNJ   = 7'h10;
  localparam logic [6:0] F_FMINMAX = 7'h14;
  localparam logic [6:0] F_FCVT_W  = 7'h60;
  localparam logic [6:0] F_FCVT_S  = 7'h68;
  localparam logic [6:0] F_FMV_X_W = 7'h70;
  localparam logic [6:0] F_COMPARE = 7'h50;
  localparam logic [6:0] F_FMV_W_X = 7'h78;

  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [32:0]      r_mem [DEPTH];
  logic [CNT_W-1:0] r_enc_count;
  logic [CNT_W-1:0] r_illegal_count;

  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic        w_illegal;
  logic        w_rm_bad;
  logic [31:0] w_word;
  logic [31:0] w_instr;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = in_valid && !w_full;
  assign w_pop   = !w_empty && out_ready;
  assign w_rm_bad = (rm == 3'b101) || (rm == 3'b110);

  always_comb begin
    w_word    = 32'h0;
    w_illegal = 1'b0;
    case (fp_op)
      OP_FLW: w_word = {offset, rs1, 3'b010, rd, fp_op};
      OP_FSW: w_word = {offset[11:5], rs2, rs1, 3'b010, offset[4:0], fp_op};
      OP_FMADD, OP_FMSUB, OP_FNMSUB, OP_FNMADD: begin
        w_word    = {rs3, fmt, rs2, rs1, rm, rd, fp_op};
        w_illegal = (fmt != 2'b00) || w_rm_bad;
      end
      OP_FP: begin
        w_word = {func, rs2, rs1, rm, rd, fp_op};
        case (func)
          F_FADD, F_FSUB, F_FMUL, F_FDIV: w_illegal = w_rm_bad;
          F_FSQRT:             w_illegal = w_rm_bad || (rs2 != 5'd0);
          F_FSGNJ, F_COMPARE:  w_illegal = (rm > 3'b010);
          F_FMINMAX, F_FMV_X_W: w_illegal = (rm > 3'b001);
          F_FMV_W_X:           w_illegal = (rm != 3'b000) || (rs2 != 5'd0);
          F_FCVT_W, F_FCVT_S:  w_illegal = w_rm_bad || (rs2 > 5'd1);
          default:             w_illegal = 1'b1;
        endcase
      end
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_instr = w_illegal ? 32'h0 : w_word;

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {w_illegal, w_instr};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_enc_count     <= '0;
      r_illegal_count <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_illegal) begin
          if (r_illegal_count != '1) r_illegal_count <= r_illegal_count + CNT_W'(1);
        end else begin
          if (r_enc_count != '1) r_enc_count <= r_enc_count + CNT_W'(1);
        end
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  assign in_ready      = !w_full;
  assign out_valid     = !w_empty;
  assign out_instr     = w_empty ? 32'h0 : r_mem[r_rd_ptr[AW-1:0]][31:0];
  assign out_illegal   = w_empty ? 1'b0  : r_mem[r_rd_ptr[AW-1:0]][32];
  assign enc_count     = r_enc_count;
  assign illegal_count = r_illegal_count;
endmodule
